// File: rtl/spc_pcx_pkg.sv
// Shared constants, destination encodings and FSM type for the core-side PCX
// request issuer.
package spc_pcx_pkg;

    localparam int DEST_W  = 5;
    localparam int PKT_W   = 124;
    localparam int CREDITS = 2;
    localparam int CNT_W   = $clog2(CREDITS + 1);

    localparam logic [DEST_W-1:0] DEST_L2B0 = 5'b00001;
    localparam logic [DEST_W-1:0] DEST_L2B1 = 5'b00010;
    localparam logic [DEST_W-1:0] DEST_L2B2 = 5'b00100;
    localparam logic [DEST_W-1:0] DEST_L2B3 = 5'b01000;
    localparam logic [DEST_W-1:0] DEST_IO   = 5'b10000;

    typedef enum logic {
        IDLE  = 1'b0,
        ATOM2 = 1'b1
    } req_state_e;

    function automatic logic is_onehot(input logic [DEST_W-1:0] d);
        return (d != '0) && ((d & (d - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/spc_pcx_credit_ctr.sv
// One per-destination PCX queue credit counter: saturating up/down with an
// overflow pulse when a grant arrives while already full.
module spc_pcx_credit_ctr
    import spc_pcx_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    logic [CNT_W-1:0] count_reg;

    // A simultaneous grant and accept cancel out, so only a lone grant can overflow.
    assign ovf   = inc && !dec && (count_reg == FULL);
    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= FULL;
        end else if (inc && !dec && (count_reg != FULL)) begin
            count_reg <= count_reg + 1'b1;
        end else if (dec && !inc && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/spc_pcx_req_ctl.sv
// Core-side PCX request issuer: credit-gated accept, atomic pair sequencing and
// the pq/pa output pipeline. Define SPC_PCX_REQ_ERR_EN to build protocol error checks.
module spc_pcx_req_ctl
    import spc_pcx_pkg::*;
(
    input  logic                    rclk,
    input  logic                    reset,
    input  logic                    ifc_req_vld,
    input  logic [DEST_W-1:0]       ifc_req_dest,
    input  logic                    ifc_req_atom,
    input  logic [PKT_W-1:0]        ifc_req_data,
    output logic                    ifc_req_ack,
    output logic [DEST_W-1:0]       spc_pcx_req_pq,
    output logic                    spc_pcx_atom_pq,
    output logic [PKT_W-1:0]        spc_pcx_data_pa,
    input  logic [DEST_W-1:0]       pcx_spc_grant_px,
    output logic [DEST_W*CNT_W-1:0] spc_pcx_credit,
    output logic                    spc_pcx_err
);

    req_state_e        state_reg;
    logic [DEST_W-1:0] atom_dest_reg;
    logic [DEST_W-1:0] req_pq_reg;
    logic              atom_pq_reg;
    logic [PKT_W-1:0]  data_s1_reg;
    logic [PKT_W-1:0]  data_pa_reg;

    logic [CNT_W-1:0]  credit [DEST_W];
    logic [DEST_W-1:0] ovf;
    logic [DEST_W-1:0] dec;
    logic [CNT_W-1:0]  sel_credit;
    logic              dest_ok;
    logic              ack;

    assign dest_ok = is_onehot(ifc_req_dest);

    always_comb begin
        sel_credit = '0;
        for (int i = 0; i < DEST_W; i++) begin
            if (ifc_req_dest[i]) sel_credit = sel_credit | credit[i];
        end
    end

    // An atomic first half needs a full queue so its second half can never be refused.
    always_comb begin
        ack = 1'b0;
        if (!reset && ifc_req_vld && dest_ok) begin
            if (state_reg == ATOM2)
                ack = (ifc_req_dest == atom_dest_reg);
            else if (ifc_req_atom)
                ack = (sel_credit == CNT_W'(CREDITS));
            else
                ack = (sel_credit != '0);
        end
    end

    assign ifc_req_ack = ack;

    for (genvar gi = 0; gi < DEST_W; gi++) begin : g_credit
        assign dec[gi] = ack & ifc_req_dest[gi];

        spc_pcx_credit_ctr u_ctr (
            .clk   (rclk),
            .srst  (reset),
            .inc   (pcx_spc_grant_px[gi]),
            .dec   (dec[gi]),
            .count (credit[gi]),
            .ovf   (ovf[gi])
        );

        assign spc_pcx_credit[gi*CNT_W +: CNT_W] = credit[gi];
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            state_reg     <= IDLE;
            atom_dest_reg <= '0;
            req_pq_reg    <= '0;
            atom_pq_reg   <= 1'b0;
            data_s1_reg   <= '0;
            data_pa_reg   <= '0;
        end else begin
            req_pq_reg  <= ack ? ifc_req_dest : '0;
            atom_pq_reg <= ack && (state_reg == IDLE) && ifc_req_atom;
            data_s1_reg <= ack ? ifc_req_data : '0;
            data_pa_reg <= data_s1_reg;
            if (ack) begin
                case (state_reg)
                    IDLE: begin
                        if (ifc_req_atom) begin
                            state_reg     <= ATOM2;
                            atom_dest_reg <= ifc_req_dest;
                        end
                    end
                    ATOM2:   state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign spc_pcx_req_pq  = req_pq_reg;
    assign spc_pcx_atom_pq = atom_pq_reg;
    assign spc_pcx_data_pa = data_pa_reg;

`ifdef SPC_PCX_REQ_ERR_EN
    logic err_reg;
    logic err_event;

    assign err_event = (ifc_req_vld && !dest_ok)
                     || (ifc_req_vld && dest_ok && (state_reg == ATOM2)
                         && (ifc_req_dest != atom_dest_reg))
                     || (|ovf);

    always_ff @(posedge rclk) begin
        if (reset)
            err_reg <= 1'b0;
        else if (err_event)
            err_reg <= 1'b1;
    end

    assign spc_pcx_err = err_reg;
`else
    logic unused_ovf;
    assign unused_ovf  = |ovf;
    assign spc_pcx_err = 1'b0;
`endif

endmodule

// File: tb/tb_spc_pcx_req_ctl.sv
// Directed bench for spc_pcx_req_ctl with a per-cycle behavioural model check
// plus literal expectations at the key points of each scenario.
module tb_spc_pcx_req_ctl;
    import spc_pcx_pkg::*;

`ifdef SPC_PCX_REQ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                    rclk = 1'b0;
    logic                    reset;
    logic                    vld;
    logic [DEST_W-1:0]       dest;
    logic                    atom;
    logic [PKT_W-1:0]        data;
    logic                    ack;
    logic [DEST_W-1:0]       pq;
    logic                    atom_pq;
    logic [PKT_W-1:0]        data_pa;
    logic [DEST_W-1:0]       grant;
    logic [DEST_W*CNT_W-1:0] credit;
    logic                    err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    spc_pcx_req_ctl dut (
        .rclk             (rclk),
        .reset            (reset),
        .ifc_req_vld      (vld),
        .ifc_req_dest     (dest),
        .ifc_req_atom     (atom),
        .ifc_req_data     (data),
        .ifc_req_ack      (ack),
        .spc_pcx_req_pq   (pq),
        .spc_pcx_atom_pq  (atom_pq),
        .spc_pcx_data_pa  (data_pa),
        .pcx_spc_grant_px (grant),
        .spc_pcx_credit   (credit),
        .spc_pcx_err      (err)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: integer credits, a pair-in-progress flag and output expectations.
    int                m_cr [DEST_W];
    bit                m_atom2;
    logic [DEST_W-1:0] m_adest;
    logic [DEST_W-1:0] m_pq;
    bit                m_apq;
    logic [PKT_W-1:0]  m_s1;
    logic [PKT_W-1:0]  m_pa;
    bit                m_err;

    task automatic model_reset();
        for (int i = 0; i < DEST_W; i++) m_cr[i] = CREDITS;
        m_atom2 = 1'b0;
        m_adest = '0;
        m_pq    = '0;
        m_apq   = 1'b0;
        m_s1    = '0;
        m_pa    = '0;
        m_err   = 1'b0;
    endtask

    initial model_reset();

    always @(negedge rclk) begin
        bit                      oh;
        bit                      e_ack;
        int                      di;
        int                      nc;
        logic [DEST_W*CNT_W-1:0] e_cr;
        if (chk_en) begin
            oh = ($countones(dest) == 1);
            di = 0;
            for (int i = 0; i < DEST_W; i++) if (dest[i]) di = i;
            e_ack = 1'b0;
            if (!reset && vld && oh) begin
                if (m_atom2)   e_ack = (dest == m_adest);
                else if (atom) e_ack = (m_cr[di] == CREDITS);
                else           e_ack = (m_cr[di] >= 1);
            end
            for (int i = 0; i < DEST_W; i++) e_cr[i*CNT_W +: CNT_W] = CNT_W'(m_cr[i]);

            check("cyc_ack", ack, e_ack);
            check("cyc_pq", pq, m_pq);
            check("cyc_atom_pq", atom_pq, m_apq);
            check("cyc_data_pa", data_pa, m_pa);
            check("cyc_credit", credit, e_cr);
            check("cyc_err", err, m_err);
            if (e_ack)
                $display("t=%0t accept dest=%b atom=%0d pair2=%0d data=%h", $time, dest, atom, m_atom2, data);

            if (reset) begin
                model_reset();
            end else begin
                if (vld && !oh) m_err = m_err | ERR_EN;
                if (m_atom2 && vld && oh && dest != m_adest) m_err = m_err | ERR_EN;
                m_pa  = m_s1;
                m_s1  = e_ack ? data : '0;
                m_pq  = e_ack ? dest : '0;
                m_apq = e_ack && !m_atom2 && atom;
                for (int i = 0; i < DEST_W; i++) begin
                    nc = m_cr[i] - int'(e_ack && dest[i]) + int'(grant[i]);
                    if (nc > CREDITS) begin
                        nc    = CREDITS;
                        m_err = m_err | ERR_EN;
                    end
                    m_cr[i] = nc;
                end
                if (e_ack) begin
                    if (m_atom2) begin
                        m_atom2 = 1'b0;
                    end else if (atom) begin
                        m_atom2 = 1'b1;
                        m_adest = dest;
                    end
                end
            end
        end
    end

    function automatic logic [PKT_W-1:0] pat(input int k);
        return {4'(k), {15{8'(k * 17 + 3)}}};
    endfunction

    task automatic next();
        @(posedge rclk);
        #1;
    endtask

    task automatic settle();
        @(negedge rclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DEST_W-1:0] d, input logic a,
                         input logic [PKT_W-1:0] p, input logic [DEST_W-1:0] g);
        vld   = v;
        dest  = d;
        atom  = a;
        data  = p;
        grant = g;
    endtask

    task automatic cyc(input logic v, input logic [DEST_W-1:0] d, input logic a,
                       input logic [PKT_W-1:0] p, input logic [DEST_W-1:0] g);
        next();
        drive(v, d, a, p, g);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        next();
        next();
        chk_en = 1'b1;
        settle();
        check("rst_ack", ack, 1'b0);
        check("rst_credit", credit, 10'b1010101010);
        check("rst_pq", pq, 5'b0);
        check("rst_err", err, 1'b0);

        // Single packet to bank 0: ack in N, pq in N+1, payload in N+2.
        next();
        reset = 1'b0;
        drive(1'b1, DEST_L2B0, 1'b0, pat(1), '0);
        settle();
        check("p1_ack", ack, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, '0);
        settle();
        check("p1_pq", pq, 5'b00001);
        check("p1_credit0", credit[1:0], 2'd1);
        cyc(1'b0, '0, 1'b0, '0, '0);
        settle();
        check("p1_data_pa", data_pa, pat(1));
        check("p1_pq_clear", pq, 5'b0);

        // Accept and grant to the same bank in one cycle leaves the count unchanged.
        cyc(1'b1, DEST_L2B0, 1'b0, pat(2), DEST_L2B0);
        settle();
        check("same_ack", ack, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, '0);
        settle();
        check("same_credit0", credit[1:0], 2'd1);
        cyc(1'b0, '0, 1'b0, '0, DEST_L2B0);
        cyc(1'b0, '0, 1'b0, '0, '0);
        settle();
        check("restore_credit0", credit[1:0], 2'd2);

        // Three packets to bank 1: the third waits for a grant, seen one cycle later.
        cyc(1'b1, DEST_L2B1, 1'b0, pat(3), '0);
        settle();
        check("b1_ack1", ack, 1'b1);
        cyc(1'b1, DEST_L2B1, 1'b0, pat(4), '0);
        settle();
        check("b1_ack2", ack, 1'b1);
        cyc(1'b1, DEST_L2B1, 1'b0, pat(5), '0);
        settle();
        check("b1_stall", ack, 1'b0);
        cyc(1'b1, DEST_L2B1, 1'b0, pat(5), DEST_L2B1);
        settle();
        check("b1_grant_no_comb", ack, 1'b0);
        cyc(1'b1, DEST_L2B1, 1'b0, pat(5), '0);
        settle();
        check("b1_ack3", ack, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, '0);
        settle();
        check("b1_credit", credit[3:2], 2'd0);
        check("b1_pq", pq, 5'b00010);
        cyc(1'b0, '0, 1'b0, '0, DEST_L2B1);
        cyc(1'b0, '0, 1'b0, '0, DEST_L2B1);

        // Atomic pair to bank 2: needs full credit; other banks blocked until pair done.
        cyc(1'b1, DEST_L2B2, 1'b0, pat(6), '0);
        settle();
        check("at_pre_ack", ack, 1'b1);
        cyc(1'b1, DEST_L2B2, 1'b1, pat(7), '0);
        settle();
        check("at_held", ack, 1'b0);
        cyc(1'b1, DEST_L2B2, 1'b1, pat(7), DEST_L2B2);
        settle();
        check("at_held_grant", ack, 1'b0);
        cyc(1'b1, DEST_L2B2, 1'b1, pat(7), '0);
        settle();
        check("at_first_ack", ack, 1'b1);
        cyc(1'b1, DEST_L2B3, 1'b0, pat(8), '0);
        settle();
        check("at_block_other", ack, 1'b0);
        check("at_first_atom_pq", atom_pq, 1'b1);
        check("at_first_credit", credit[5:4], 2'd1);
        cyc(1'b1, DEST_L2B3, 1'b0, pat(8), '0);
        settle();
        check("at_block_other2", ack, 1'b0);
        cyc(1'b1, DEST_L2B2, 1'b1, pat(9), '0);
        settle();
        check("at_second_ack", ack, 1'b1);
        check("at_err_mismatch", err, ERR_EN);
        cyc(1'b1, DEST_L2B3, 1'b0, pat(8), '0);
        settle();
        check("at_other_after", ack, 1'b1);
        check("at_second_atom_pq", atom_pq, 1'b0);
        check("at_second_pq", pq, 5'b00100);
        check("at_credit_empty", credit[5:4], 2'd0);

        // Reset, then a grant to a full IO queue saturates and flags overflow.
        next();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        cyc(1'b0, '0, 1'b0, '0, DEST_IO);
        reset = 1'b0;
        cyc(1'b0, '0, 1'b0, '0, '0);
        settle();
        check("ovf_credit4", credit[9:8], 2'd2);
        check("ovf_err", err, ERR_EN);

        // Invalid destinations are never accepted.
        next();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        cyc(1'b1, 5'b00011, 1'b0, pat(10), '0);
        reset = 1'b0;
        settle();
        check("inv_err_clear", err, 1'b0);
        cyc(1'b1, 5'b00011, 1'b0, pat(10), '0);
        settle();
        check("inv_multi_ack", ack, 1'b0);
        cyc(1'b1, 5'b00000, 1'b0, pat(10), '0);
        settle();
        check("inv_zero_ack", ack, 1'b0);
        check("inv_err", err, ERR_EN);

        // Reset in the middle of an atomic pair abandons it and clears the pipeline.
        next();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        cyc(1'b1, DEST_L2B0, 1'b1, pat(11), '0);
        reset = 1'b0;
        settle();
        check("ra_first_ack", ack, 1'b1);
        next();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        settle();
        check("ra_pq_inflight", pq, 5'b00001);
        next();
        reset = 1'b0;
        drive(1'b1, DEST_L2B1, 1'b0, pat(12), '0);
        settle();
        check("ra_pq_clear", pq, 5'b0);
        check("ra_atom_clear", atom_pq, 1'b0);
        check("ra_data_clear", data_pa, '0);
        check("ra_credit", credit, 10'b1010101010);
        check("ra_idle_ack", ack, 1'b1);
        cyc(1'b1, DEST_L2B0, 1'b1, pat(13), '0);
        settle();
        check("ra_atom_again", ack, 1'b1);
        cyc(1'b1, DEST_L2B0, 1'b0, pat(14), '0);
        settle();
        check("ra_atom_pq", atom_pq, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, '0);
        next();
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
